// File: rtl/motor_pwm_driver_pkg.sv
// Shared types, speed pattern constants and encode/decode helpers for the motor PWM driver.
package motor_pkg;

  localparam int unsigned NUM_MOTORS = 4;

  typedef logic [1:0] speed_lvl_t;

  localparam logic [7:0] PAT_LVL0 = 8'b0000_0000;
  localparam logic [7:0] PAT_LVL1 = 8'b0000_1111;
  localparam logic [7:0] PAT_LVL2 = 8'b0011_0011;
  localparam logic [7:0] PAT_LVL3 = 8'b1100_0011;

  typedef struct packed {
    logic       valid;
    speed_lvl_t lvl;
  } decode_t;

  function automatic logic [7:0] lvl2pat(speed_lvl_t lvl);
    logic [7:0] pat;
    case (lvl)
      2'd0:    pat = PAT_LVL0;
      2'd1:    pat = PAT_LVL1;
      2'd2:    pat = PAT_LVL2;
      default: pat = PAT_LVL3;
    endcase
    return pat;
  endfunction

  // Only exact matches decode; anything else comes back with valid cleared.
  function automatic decode_t pat2lvl(logic [7:0] pat);
    decode_t d;
    d.valid = 1'b1;
    d.lvl   = '0;
    case (pat)
      PAT_LVL0: d.lvl = 2'd0;
      PAT_LVL1: d.lvl = 2'd1;
      PAT_LVL2: d.lvl = 2'd2;
      PAT_LVL3: d.lvl = 2'd3;
      default:  d.valid = 1'b0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/motor_pwm_driver_if.sv
// Load/drive bus between the speed controller (master) and the PWM driver (slave).
interface motor_pwm_if;
  import motor_pkg::*;

  logic                    load;
  logic [1:0]              motor_sel;
  logic [7:0]              pattern;
  logic [NUM_MOTORS-1:0]   pwm;
  logic [2*NUM_MOTORS-1:0] level;
  logic                    pattern_err;
  logic                    frame;

  modport master (
    output load, motor_sel, pattern,
    input  pwm, level, pattern_err, frame
  );

  modport slave (
    input  load, motor_sel, pattern,
    output pwm, level, pattern_err, frame
  );

endinterface

// File: rtl/motor_pwm_driver_timebase.sv
// Shared PWM timebase: prescaler plus 3-bit pattern slot index, frame pulse on the last clock.
module motor_pwm_timebase #(
  parameter int unsigned PRESCALE = 4
) (
  input  logic       clk,
  input  logic       rst,
  output logic [2:0] bit_idx,
  output logic       frame
);

  localparam int unsigned   PW         = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] presc;
  logic          wrap;

  assign wrap  = (presc == PRESC_LAST);
  assign frame = wrap && (bit_idx == 3'd7);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc   <= '0;
      bit_idx <= '0;
    end else if (wrap) begin
      presc   <= '0;
      bit_idx <= bit_idx + 3'd1;
    end else begin
      presc   <= presc + 1'b1;
    end
  end

endmodule

// File: rtl/motor_pwm_driver.sv
// Four-motor PWM driver: decodes speed patterns into per-motor targets, applies them at frame
// boundaries and serializes the active pattern LSB first. Optional MOTOR_RAMP_EN steps one level per frame.
module motor_pwm_driver
  import motor_pkg::*;
#(
  parameter int unsigned PRESCALE = 4
) (
  input logic         clk,
  input logic         rst,
  motor_pwm_if.slave  bus
);

  speed_lvl_t target [NUM_MOTORS];
  speed_lvl_t active [NUM_MOTORS];
  speed_lvl_t nxt    [NUM_MOTORS];

  logic [2:0]              bit_idx;
  logic                    frame;
  decode_t                 dec;
  logic [NUM_MOTORS-1:0]   pwm_q;
  logic [NUM_MOTORS-1:0]   drive;
  logic [2*NUM_MOTORS-1:0] level_w;
  logic                    err_q;

  motor_pwm_timebase #(.PRESCALE(PRESCALE)) u_timebase (
    .clk     (clk),
    .rst     (rst),
    .bit_idx (bit_idx),
    .frame   (frame)
  );

  assign dec = pat2lvl(bus.pattern);

  always_comb begin
    for (int unsigned i = 0; i < NUM_MOTORS; i++) begin
`ifdef MOTOR_RAMP_EN
      nxt[i] = active[i];
      if (active[i] < target[i])
        nxt[i] = active[i] + 2'd1;
      else if (active[i] > target[i])
        nxt[i] = active[i] - 2'd1;
`else
      nxt[i] = target[i];
`endif
    end
  end

  always_comb begin
    drive   = '0;
    level_w = '0;
    for (int unsigned i = 0; i < NUM_MOTORS; i++) begin
      logic [7:0] pat;
      pat              = lvl2pat(active[i]);
      drive[i]         = pat[bit_idx];
      level_w[2*i +: 2] = active[i];
    end
  end

  // active samples the pre-edge target, so a load landing on the frame edge waits one more frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_MOTORS; i++) begin
        target[i] <= '0;
        active[i] <= '0;
      end
      pwm_q <= '0;
      err_q <= 1'b0;
    end else begin
      err_q <= bus.load && !dec.valid;
      if (bus.load && dec.valid)
        target[bus.motor_sel] <= dec.lvl;
      if (frame) begin
        for (int unsigned i = 0; i < NUM_MOTORS; i++)
          active[i] <= nxt[i];
      end
      pwm_q <= drive;
    end
  end

  assign bus.pwm         = pwm_q;
  assign bus.level       = level_w;
  assign bus.pattern_err = err_q;
  assign bus.frame       = frame;

endmodule

// File: tb/tb_motor_pwm_driver.sv
// Randomized and directed bench for motor_pwm_driver against a cycle-count based reference model.
module tb_motor_pwm_driver;

  localparam int P     = 2;
  localparam int FRAME = 8 * P;

  logic clk = 1'b0;
  logic rst = 1'b1;

  motor_pwm_if bus();

  motor_pwm_driver #(.PRESCALE(P)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [7:0] pats [4] = '{8'h00, 8'h0F, 8'h33, 8'hC3};
  int         tgt  [4];
  int         act  [4];
  int         cnt;
  logic [3:0] exp_pwm;
  logic       exp_err;

  task automatic check_eq(string tag, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int decode(logic [7:0] p);
    for (int i = 0; i < 4; i++)
      if (pats[i] == p) return i;
    return -1;
  endfunction

  function automatic logic [7:0] model_level();
    logic [7:0] l;
    for (int i = 0; i < 4; i++) l[2*i +: 2] = act[i][1:0];
    return l;
  endfunction

  // Model: the clock count since reset release fixes slot and frame position.
  task automatic step();
    int  b;
    int  lv;
    bit  fr;
    @(posedge clk);
    if (rst) begin
      exp_pwm = '0;
      exp_err = 1'b0;
    end else begin
      fr = (cnt % FRAME) == FRAME - 1;
      b  = (cnt / P) % 8;
      for (int i = 0; i < 4; i++) exp_pwm[i] = pats[act[i]][b];
      lv      = decode(bus.pattern);
      exp_err = bus.load && (lv < 0);
      if (fr) begin
        for (int i = 0; i < 4; i++) begin
`ifdef MOTOR_RAMP_EN
          if (tgt[i] > act[i]) act[i] = act[i] + 1;
          else if (tgt[i] < act[i]) act[i] = act[i] - 1;
`else
          act[i] = tgt[i];
`endif
        end
      end
      if (bus.load && lv >= 0) tgt[bus.motor_sel] = lv;
      cnt++;
    end
    #1;
    check_eq("pwm", bus.pwm, exp_pwm);
    check_eq("level", bus.level, model_level());
    check_eq("pattern_err", bus.pattern_err, exp_err);
    check_eq("frame", bus.frame, !rst && ((cnt % FRAME) == FRAME - 1));
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    #2;
    for (int i = 0; i < 4; i++) begin
      tgt[i] = 0;
      act[i] = 0;
    end
    cnt = 0;
    check_eq("rst_pwm", bus.pwm, 0);
    check_eq("rst_level", bus.level, 0);
    check_eq("rst_err", bus.pattern_err, 0);
    check_eq("rst_frame", bus.frame, 0);
    repeat (3) step();
    rst = 1'b0;
  endtask

  task automatic do_load(logic [1:0] sel, logic [7:0] pat);
    bus.load      = 1'b1;
    bus.motor_sel = sel;
    bus.pattern   = pat;
    step();
    bus.load      = 1'b0;
  endtask

  task automatic to_boundary();
    do step(); while ((cnt % FRAME) != 0);
  endtask

  task automatic to_frame_cycle();
    while ((cnt % FRAME) != FRAME - 1) step();
  endtask

  initial begin
    logic [7:0] seq;
    int         n;
    bus.load      = 1'b0;
    bus.motor_sel = '0;
    bus.pattern   = '0;
    #3;
    apply_reset();

    // Motor 1 to level 2, then watch its serialized pattern
    to_boundary();
    do_load(2'd1, 8'h33);
    to_boundary();
`ifndef MOTOR_RAMP_EN
    check_eq("m1_level", bus.level[3:2], 2);
    seq = 8'b0011_0011;
    for (int k = 0; k < 16; k++) begin
      step();
      check_eq("m1_pwm_seq", bus.pwm[1], seq[k/2]);
    end
`endif

    // Rejected pattern
    do_load(2'd2, 8'hAA);
    check_eq("err_pulse", bus.pattern_err, 1);
    step();
    check_eq("err_clear", bus.pattern_err, 0);
    to_boundary();
    check_eq("m2_unchanged", bus.level[5:4], 0);

    // Last load wins, then a load on the frame cycle
    to_boundary();
    do_load(2'd0, 8'h0F);
    do_load(2'd0, 8'hC3);
    to_boundary();
`ifndef MOTOR_RAMP_EN
    check_eq("last_wins", bus.level[1:0], 3);
`endif
    to_frame_cycle();
    do_load(2'd0, 8'h00);
`ifndef MOTOR_RAMP_EN
    check_eq("collide_old", bus.level[1:0], 3);
`endif
    to_boundary();
`ifndef MOTOR_RAMP_EN
    check_eq("collide_new", bus.level[1:0], 0);
`endif

    // All four motors in consecutive cycles
    apply_reset();
    for (int m = 0; m < 4; m++) do_load(m[1:0], pats[m]);
    to_boundary();
`ifndef MOTOR_RAMP_EN
    check_eq("indep_level", bus.level, 8'hE4);
`endif
    repeat (FRAME) step();

`ifdef MOTOR_RAMP_EN
    apply_reset();
    do_load(2'd3, 8'hC3);
    for (int k = 1; k <= 3; k++) begin
      to_boundary();
      check_eq("ramp_up", bus.level[7:6], k);
    end
    do_load(2'd3, 8'h00);
    for (int k = 2; k >= 0; k--) begin
      to_boundary();
      check_eq("ramp_down", bus.level[7:6], k);
    end
`endif

    // Random traffic
    for (int k = 0; k < 400; k++) begin
      bus.load      = ($urandom_range(0, 1) == 1);
      bus.motor_sel = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) bus.pattern = 8'($urandom);
      else                           bus.pattern = pats[$urandom_range(0, 3)];
      step();
    end
    bus.load = 1'b0;

    // Mid-frame reset and restart distance
    repeat (5) step();
    apply_reset();
    n = 0;
    do begin
      step();
      n++;
    end while (bus.frame !== 1'b1 && n < 40);
    check_eq("first_frame_clk", n + 1, FRAME);
    repeat (FRAME) step();
    check_eq("frame_period", bus.frame, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
